// File: rtl/temporizador_turno_pkg.sv
// Shared state codes for the turn timer, reused by the control unit and the debug display decoder.
package temporizador_turno_pkg;

  localparam logic [1:0] ST_OCIOSO   = 2'b00;
  localparam logic [1:0] ST_CONTANDO = 2'b01;
  localparam logic [1:0] ST_PAUSADO  = 2'b10;
  localparam logic [1:0] ST_ESGOTADO = 2'b11;

  typedef enum logic [1:0] {
    OCIOSO   = ST_OCIOSO,
    CONTANDO = ST_CONTANDO,
    PAUSADO  = ST_PAUSADO,
    ESGOTADO = ST_ESGOTADO
  } estado_t;

endpackage

// File: rtl/temporizador_turno_divisor_tick.sv
// Mod-CLK_DIV prescaler: counts while enabled and flags the cycle on which it wraps back to zero.
module divisor_tick #(
  parameter int CLK_DIV = 50000000,
  parameter int DIV_W   = 26
) (
  input  logic clock,
  input  logic clear_i,
  input  logic enable_i,
  output logic wrap_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic             at_top;

  assign at_top = (cnt_q == DIV_W'(CLK_DIV - 1));
  assign wrap_o = enable_i && at_top;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = at_top ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/temporizador_turno.sv
// Turn timer: loads TEMPO seconds on iniciar, counts down on each prescaler wrap, pulses timeout at zero.
//   state    | meaning
//   OCIOSO   | idle, no turn in progress
//   CONTANDO | counting down remaining seconds
//   PAUSADO  | countdown and prescaler frozen
//   ESGOTADO | turn expired, restante held at 0
module temporizador_turno
  import temporizador_turno_pkg::*;
#(
  parameter int CLK_DIV = 50000000,
  parameter int DIV_W   = 26,
  parameter int TEMPO   = 30,
  parameter int T_W     = 6
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           iniciar,
  input  logic           pausa,
  input  logic           cancela,
  output logic [T_W-1:0] restante,
  output logic           ativo,
  output logic           pausado,
  output logic           timeout,
  output logic           pronto,
  output logic [1:0]     db_estado
);

  estado_t        state_q, state_d;
  logic [T_W-1:0] restante_q, restante_d;
  logic           timeout_q, timeout_d;
  logic           clr_div;
  logic           wrap;

  divisor_tick #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_div (
    .clock    (clock),
    .clear_i  (reset || clr_div),
    .enable_i (state_q == CONTANDO),
    .wrap_o   (wrap)
  );

  always_comb begin
    state_d    = state_q;
    restante_d = restante_q;
    timeout_d  = 1'b0;
    clr_div    = 1'b0;
    unique case (state_q)
      OCIOSO: begin
        if (iniciar) begin
          state_d    = CONTANDO;
          restante_d = T_W'(TEMPO);
          clr_div    = 1'b1;
        end
      end
      CONTANDO: begin
        if (cancela) begin
          state_d    = OCIOSO;
          restante_d = '0;
          clr_div    = 1'b1;
        end else if (iniciar) begin
          restante_d = T_W'(TEMPO);
          clr_div    = 1'b1;
        end else begin
          if (wrap && restante_q != '0) begin
            restante_d = restante_q - T_W'(1);
            if (restante_q == T_W'(1)) begin
              state_d   = ESGOTADO;
              timeout_d = 1'b1;
            end
          end
          // expiry on the final wrap takes precedence over entering pause
          if (pausa && state_d == CONTANDO) state_d = PAUSADO;
        end
      end
      PAUSADO: begin
        if (cancela) begin
          state_d    = OCIOSO;
          restante_d = '0;
          clr_div    = 1'b1;
        end else if (iniciar) begin
          state_d    = CONTANDO;
          restante_d = T_W'(TEMPO);
          clr_div    = 1'b1;
        end else if (!pausa) begin
          state_d = CONTANDO;
        end
      end
      ESGOTADO: begin
        if (cancela) begin
          state_d    = OCIOSO;
          restante_d = '0;
          clr_div    = 1'b1;
        end else if (iniciar) begin
          state_d    = CONTANDO;
          restante_d = T_W'(TEMPO);
          clr_div    = 1'b1;
        end
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= OCIOSO;
      restante_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      restante_q <= restante_d;
      timeout_q  <= timeout_d;
    end
  end

  assign restante  = restante_q;
  assign timeout   = timeout_q;
  assign ativo     = (state_q == CONTANDO);
  assign pausado   = (state_q == PAUSADO);
  assign pronto    = (state_q == OCIOSO) || (state_q == ESGOTADO);
  assign db_estado = state_q;

endmodule

// File: tb/tb_temporizador_turno.sv
// Directed bench for temporizador_turno with CLK_DIV=4, TEMPO=3; expected values computed by hand.
module tb_temporizador_turno;

  localparam int CLK_DIV = 4;
  localparam int DIV_W   = 3;
  localparam int TEMPO   = 3;
  localparam int T_W     = 2;

  logic           clock = 1'b0;
  logic           reset, iniciar, pausa, cancela;
  logic [T_W-1:0] restante;
  logic           ativo, pausado, timeout, pronto;
  logic [1:0]     db_estado;

  int n_cmp = 0;
  int n_bad = 0;

  temporizador_turno #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W),
    .TEMPO   (TEMPO),
    .T_W     (T_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .pausa     (pausa),
    .cancela   (cancela),
    .restante  (restante),
    .ativo     (ativo),
    .pausado   (pausado),
    .timeout   (timeout),
    .pronto    (pronto),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  task automatic start();
    iniciar = 1'b1;
    step(1);
    iniciar = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_restante"}, 32'(restante), 0);
    chk({tag, "_ativo"},    32'(ativo),    0);
    chk({tag, "_pausado"},  32'(pausado),  0);
    chk({tag, "_timeout"},  32'(timeout),  0);
    chk({tag, "_pronto"},   32'(pronto),   1);
    chk({tag, "_estado"},   32'(db_estado), 0);
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; pausa = 1'b0; cancela = 1'b0;
    #2;
    do_reset();
    chk_reset_outs("rst");
    chk("rst_presc", 32'(dut.u_div.cnt_q), 0);

    // idle ignores pausa and cancela
    pausa = 1'b1; cancela = 1'b1;
    step(2);
    pausa = 1'b0; cancela = 1'b0;
    chk("idle_ign_estado", 32'(db_estado), 0);

    // full run
    start();
    chk("run_e0_rest", 32'(restante), 3);
    chk("run_e0_ativo", 32'(ativo), 1);
    step(3);
    chk("run_e3_rest", 32'(restante), 3);
    step(1);
    chk("run_e4_rest", 32'(restante), 2);
    step(4);
    chk("run_e8_rest", 32'(restante), 1);
    step(3);
    chk("run_e11_rest", 32'(restante), 1);
    chk("run_e11_tmo", 32'(timeout), 0);
    step(1);
    chk("run_e12_rest", 32'(restante), 0);
    chk("run_e12_estado", 32'(db_estado), 3);
    chk("run_e12_tmo", 32'(timeout), 1);
    chk("run_e12_pronto", 32'(pronto), 1);
    chk("run_e12_ativo", 32'(ativo), 0);
    step(1);
    chk("run_e13_tmo", 32'(timeout), 0);
    chk("run_e13_rest", 32'(restante), 0);

    // pause
    do_reset();
    start();
    step(4);
    chk("pau_e4_rest", 32'(restante), 2);
    pausa = 1'b1;
    step(1);
    chk("pau_e5_pausado", 32'(pausado), 1);
    chk("pau_e5_estado", 32'(db_estado), 2);
    chk("pau_e5_presc", 32'(dut.u_div.cnt_q), 1);
    step(9);
    chk("pau_e14_rest", 32'(restante), 2);
    chk("pau_e14_presc", 32'(dut.u_div.cnt_q), 1);
    chk("pau_e14_pausado", 32'(pausado), 1);
    pausa = 1'b0;
    step(1);
    chk("pau_e15_ativo", 32'(ativo), 1);
    chk("pau_e15_presc", 32'(dut.u_div.cnt_q), 1);
    step(2);
    chk("pau_e17_rest", 32'(restante), 2);
    step(1);
    chk("pau_e18_rest", 32'(restante), 1);
    step(3);
    chk("pau_e21_tmo", 32'(timeout), 0);
    step(1);
    chk("pau_e22_rest", 32'(restante), 0);
    chk("pau_e22_tmo", 32'(timeout), 1);

    // restart mid-count
    do_reset();
    start();
    step(6);
    chk("rst_mid_e6_rest", 32'(restante), 2);
    start();
    chk("rst_mid_e7_rest", 32'(restante), 3);
    step(1);
    chk("rst_mid_e8_rest", 32'(restante), 3);
    step(2);
    chk("rst_mid_e10_rest", 32'(restante), 3);
    step(1);
    chk("rst_mid_e11_rest", 32'(restante), 2);

    // cancela + iniciar on a wrap edge
    do_reset();
    start();
    step(7);
    chk("can_e7_rest", 32'(restante), 2);
    cancela = 1'b1; iniciar = 1'b1;
    step(1);
    cancela = 1'b0; iniciar = 1'b0;
    chk("can_e8_estado", 32'(db_estado), 0);
    chk("can_e8_rest", 32'(restante), 0);
    chk("can_e8_tmo", 32'(timeout), 0);
    step(1);
    chk("can_e9_tmo", 32'(timeout), 0);

    // reset mid-count
    start();
    step(8);
    chk("rmc_e8_rest", 32'(restante), 1);
    iniciar = 1'b1; cancela = 1'b1; pausa = 1'b1;
    reset = 1'b1;
    step(1);
    reset = 1'b0; iniciar = 1'b0; cancela = 1'b0; pausa = 1'b0;
    chk_reset_outs("rmc_e9");
    chk("rmc_e9_presc", 32'(dut.u_div.cnt_q), 0);

    // pausa on the final wrap
    start();
    step(11);
    chk("bnd_e11_rest", 32'(restante), 1);
    pausa = 1'b1;
    step(1);
    chk("bnd_e12_estado", 32'(db_estado), 3);
    chk("bnd_e12_tmo", 32'(timeout), 1);
    chk("bnd_e12_pausado", 32'(pausado), 0);
    step(1);
    chk("bnd_e13_estado", 32'(db_estado), 3);
    chk("bnd_e13_tmo", 32'(timeout), 0);
    iniciar = 1'b1;
    step(1);
    iniciar = 1'b0; pausa = 1'b0;
    chk("bnd_reload_rest", 32'(restante), 3);
    chk("bnd_reload_estado", 32'(db_estado), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
